// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer
// Issues a four-lane vector load or store to a single-port memory, one lane
// (beat) per accepted cycle, at consecutive word addresses starting from a
// latched base. Load data returns one cycle after each accepted read beat
// and is gathered into load_vec. Every output is driven directly by a flop:
// the *_d values are computed from the next state so that outputs line up
// with the state they describe.

module vector_mem_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_store,
    input  logic [31:0] base_addr,
    input  logic [31:0] store_vec [0:3],
    input  logic        mem_stall,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [31:0] load_vec [0:3],
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]  state_q,     state_d;
    logic [1:0]  beat_idx_q,  beat_idx_d;
    logic        op_store_q,  op_store_d;
    logic [31:0] base_q,      base_d;
    logic [31:0] vec_q [0:3];
    logic [31:0] vec_d [0:3];
    logic [31:0] load_vec_q [0:3];
    logic [31:0] load_vec_d [0:3];
    // A read beat was accepted last cycle; its data is on mem_rdata now.
    logic        cap_pend_q,  cap_pend_d;
    logic [1:0]  cap_idx_q,   cap_idx_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q,    mem_we_d;
    logic        mem_re_q,    mem_re_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;

    // Next-state logic: sequencing, operand latching and load-data capture.
    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        op_store_d = op_store_q;
        base_d     = base_q;
        vec_d      = vec_q;
        load_vec_d = load_vec_q;
        cap_pend_d = 1'b0;
        cap_idx_d  = cap_idx_q;

        // Read data arrives one cycle after its beat, whatever state we are in.
        if (cap_pend_q) begin
            load_vec_d[cap_idx_q] = mem_rdata;
        end else begin
            load_vec_d = load_vec_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_store_d = op_store;
                    base_d     = base_addr;
                    vec_d      = store_vec;
                    beat_idx_d = 2'd0;
                    state_d    = ST_ACCESS;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!mem_stall) begin
                    if (!op_store_q) begin
                        cap_pend_d = 1'b1;
                        cap_idx_d  = beat_idx_q;
                    end else begin
                        cap_pend_d = 1'b0;
                    end
                    if (beat_idx_q == 2'd3) begin
                        // Loads need one extra cycle to capture the last lane.
                        state_d = op_store_q ? ST_DONE : ST_WAIT;
                    end else begin
                        beat_idx_d = beat_idx_q + 2'd1;
                    end
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_WAIT: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output pre-decode from the next state so the output flops match it.
    always_comb begin
        mem_addr_d  = 32'h0;
        mem_wdata_d = 32'h0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        if (state_d == ST_ACCESS) begin
            mem_addr_d  = base_d + {30'd0, beat_idx_d};
            mem_we_d    = op_store_d;
            mem_re_d    = !op_store_d;
            mem_wdata_d = op_store_d ? vec_d[beat_idx_d] : 32'h0;
        end else begin
            mem_addr_d  = 32'h0;
            mem_wdata_d = 32'h0;
            mem_we_d    = 1'b0;
            mem_re_d    = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, operand and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_idx_q  <= 2'd0;
            op_store_q  <= 1'b0;
            base_q      <= 32'h0;
            cap_pend_q  <= 1'b0;
            cap_idx_q   <= 2'd0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                vec_q[i]      <= 32'h0;
                load_vec_q[i] <= 32'h0;
            end
        end else begin
            state_q     <= state_d;
            beat_idx_q  <= beat_idx_d;
            op_store_q  <= op_store_d;
            base_q      <= base_d;
            cap_pend_q  <= cap_pend_d;
            cap_idx_q   <= cap_idx_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int i = 0; i < 4; i++) begin
                vec_q[i]      <= vec_d[i];
                load_vec_q[i] <= load_vec_d[i];
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign load_vec  = load_vec_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer: store, load, stall, address wrap,
// start while busy and mid-transfer reset. Expected values are hand-derived.

module tb_vector_mem_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_store;
    logic [31:0] base_addr;
    logic [31:0] store_vec [0:3];
    logic        mem_stall;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] load_vec [0:3];
    logic        busy;
    logic        done;

    int n_cmp;
    int n_fail;

    logic [31:0] sv_a [0:3];
    logic [31:0] rd_a [0:3];

    vector_mem_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_store  (op_store),
        .base_addr (base_addr),
        .store_vec (store_vec),
        .mem_stall (mem_stall),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .load_vec  (load_vec),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Idle-state output check.
    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},  {31'd0, busy},   32'd0);
        chk({tag, ".done"},  {31'd0, done},   32'd0);
        chk({tag, ".we"},    {31'd0, mem_we}, 32'd0);
        chk({tag, ".re"},    {31'd0, mem_re}, 32'd0);
        chk({tag, ".addr"},  mem_addr,        32'h0);
        chk({tag, ".wdata"}, mem_wdata,       32'h0);
    endtask

    task automatic chk_beat(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
        chk({tag, ".we"},    {31'd0, mem_we}, {31'd0, we});
        chk({tag, ".re"},    {31'd0, mem_re}, {31'd0, !we});
        chk({tag, ".addr"},  mem_addr,        addr);
        chk({tag, ".wdata"}, mem_wdata,       wdata);
        chk({tag, ".busy"},  {31'd0, busy},   32'd1);
        chk({tag, ".done"},  {31'd0, done},   32'd0);
    endtask

    task automatic issue(input logic st, input logic [31:0] base);
        start     = 1'b1;
        op_store  = st;
        base_addr = base;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        op_store  = 1'b0;
        base_addr = 32'h0;
        mem_stall = 1'b0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 4; i++) store_vec[i] = 32'h0;
        sv_a[0] = 32'hA0A0_0001; sv_a[1] = 32'hB0B0_0002;
        sv_a[2] = 32'hC0C0_0003; sv_a[3] = 32'hD0D0_0004;
        rd_a[0] = 32'h11; rd_a[1] = 32'h22; rd_a[2] = 32'h33; rd_a[3] = 32'h44;

        tick();
        tick();
        rst_n = 1'b1;
        chk_idle("reset");
        for (int i = 0; i < 4; i++) chk($sformatf("reset.lv%0d", i), load_vec[i], 32'h0);

        // Store, no stall: beats in cycles 1-4, done in cycle 5.
        for (int i = 0; i < 4; i++) store_vec[i] = sv_a[i];
        issue(1'b1, 32'h100);
        for (int k = 0; k < 4; k++) begin
            chk_beat($sformatf("st.c%0d", k + 1), 1'b1, 32'h100 + k, sv_a[k]);
            tick();
        end
        chk("st.c5.done", {31'd0, done}, 32'd1);
        chk("st.c5.busy", {31'd0, busy}, 32'd1);
        chk("st.c5.we",   {31'd0, mem_we}, 32'd0);
        tick();
        chk_idle("st.c6");
        chk("st.lv0", load_vec[0], 32'h0);

        // Load, no stall: data returns a cycle after each beat; done in cycle 6.
        mem_rdata = 32'hDEAD_0000;
        issue(1'b0, 32'h20);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) mem_rdata = rd_a[k - 1];
            chk_beat($sformatf("ld.c%0d", k + 1), 1'b0, 32'h20 + k, 32'h0);
            tick();
        end
        mem_rdata = rd_a[3];
        chk("ld.c5.busy", {31'd0, busy},   32'd1);
        chk("ld.c5.done", {31'd0, done},   32'd0);
        chk("ld.c5.re",   {31'd0, mem_re}, 32'd0);
        tick();
        mem_rdata = 32'hDEAD_BEEF;
        chk("ld.c6.done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 4; i++) chk($sformatf("ld.lv%0d", i), load_vec[i], rd_a[i]);
        tick();
        chk_idle("ld.c7");
        for (int i = 0; i < 4; i++) chk($sformatf("ld.hold%0d", i), load_vec[i], rd_a[i]);

        // Store with beat 1 stalled for two cycles: done in cycle 7.
        issue(1'b1, 32'h300);
        chk_beat("stall.c1", 1'b1, 32'h300, sv_a[0]);
        tick();
        mem_stall = 1'b1;
        chk_beat("stall.c2", 1'b1, 32'h301, sv_a[1]);
        tick();
        chk_beat("stall.c3", 1'b1, 32'h301, sv_a[1]);
        tick();
        mem_stall = 1'b0;
        chk_beat("stall.c4", 1'b1, 32'h301, sv_a[1]);
        tick();
        chk_beat("stall.c5", 1'b1, 32'h302, sv_a[2]);
        tick();
        chk_beat("stall.c6", 1'b1, 32'h303, sv_a[3]);
        tick();
        chk("stall.c7.done", {31'd0, done}, 32'd1);
        tick();
        chk_idle("stall.c8");
        for (int i = 0; i < 4; i++) chk($sformatf("stall.lv%0d", i), load_vec[i], rd_a[i]);

        // Load at the top of the address space wraps to zero.
        issue(1'b0, 32'hFFFF_FFFE);
        chk_beat("wrap.c1", 1'b0, 32'hFFFF_FFFE, 32'h0);
        tick();
        mem_rdata = 32'h5;
        chk_beat("wrap.c2", 1'b0, 32'hFFFF_FFFF, 32'h0);
        tick();
        mem_rdata = 32'h6;
        chk_beat("wrap.c3", 1'b0, 32'h0000_0000, 32'h0);
        tick();
        mem_rdata = 32'h7;
        chk_beat("wrap.c4", 1'b0, 32'h0000_0001, 32'h0);
        tick();
        mem_rdata = 32'h8;
        tick();
        chk("wrap.c6.done", {31'd0, done}, 32'd1);
        chk("wrap.lv0", load_vec[0], 32'h5);
        chk("wrap.lv3", load_vec[3], 32'h8);
        tick();

        // Start pulsed mid-transfer with different operands is ignored.
        issue(1'b1, 32'h400);
        chk_beat("busy.c1", 1'b1, 32'h400, sv_a[0]);
        tick();
        chk_beat("busy.c2", 1'b1, 32'h401, sv_a[1]);
        tick();
        start     = 1'b1;
        op_store  = 1'b0;
        base_addr = 32'h999;
        chk_beat("busy.c3", 1'b1, 32'h402, sv_a[2]);
        tick();
        start = 1'b0;
        chk_beat("busy.c4", 1'b1, 32'h403, sv_a[3]);
        tick();
        chk("busy.c5.done", {31'd0, done}, 32'd1);
        tick();
        chk_idle("busy.c6");
        chk("busy.lv0", load_vec[0], 32'h5);

        // Reset during cycle 3 of a load abandons it and clears captured data.
        issue(1'b0, 32'h50);
        tick();
        mem_rdata = 32'h77;
        chk_beat("rst.c2", 1'b0, 32'h51, 32'h0);
        tick();
        chk("rst.c3.lv0", load_vec[0], 32'h77);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_idle("rst.c4");
        for (int i = 0; i < 4; i++) chk($sformatf("rst.lv%0d", i), load_vec[i], 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rst.nodone%0d", k), {31'd0, done}, 32'd0);
        end
        issue(1'b1, 32'h10);
        for (int k = 0; k < 4; k++) begin
            chk_beat($sformatf("rst.st.c%0d", k + 1), 1'b1, 32'h10 + k, sv_a[k]);
            tick();
        end
        chk("rst.st.c5.done", {31'd0, done}, 32'd1);
        tick();
        chk_idle("rst.st.c6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_mem_sequencer.md
VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

Interface
REQ-001 Parameters: none; lanes fixed at 4, data and address fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a vector access; sampled only in IDLE.
REQ-005 op_store  input  1  1 = vector store, 0 = vector load; latched with start.
REQ-006 base_addr  input  32  address of lane 0; latched with start.
REQ-007 store_vec  input  32 x [0:3]  store data per lane; latched with start.
REQ-008 mem_stall  input  1  memory cannot accept the current beat this cycle.
REQ-009 mem_rdata  input  32  read data, valid the cycle after an accepted read beat.
REQ-010 mem_addr  output  32  beat address.
REQ-011 mem_wdata  output  32  beat write data.
REQ-012 mem_we  output  1  write strobe.
REQ-013 mem_re  output  1  read strobe.
REQ-014 load_vec  output  32 x [0:3]  gathered load result.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 done  output  1  single-cycle completion pulse.

Function
REQ-017 States: IDLE, ACCESS, WAIT, DONE; a 2-bit beat counter beat_idx tracks the lane.
REQ-018 In IDLE with start=1: latch op_store, base_addr and store_vec; clear beat_idx to 0; go to ACCESS.
REQ-019 In IDLE with start=0: remain in IDLE; start is ignored in every other state.
REQ-020 In ACCESS: mem_addr = latched base + beat_idx, modulo 2^32 (0xFFFFFFFF + 1 wraps to 0x00000000).
REQ-021 In ACCESS: mem_we = op_store and mem_re = !op_store; mem_wdata = latched store_vec[beat_idx] on stores and 0 on loads.
REQ-022 Outside ACCESS: mem_we = 0, mem_re = 0, mem_addr = 0, mem_wdata = 0.
REQ-023 A beat is accepted in an ACCESS cycle with mem_stall=0; with mem_stall=1, all mem_* outputs hold and beat_idx does not advance.
REQ-024 On accepted beat with beat_idx<3: increment beat_idx and stay in ACCESS.
REQ-025 On accepted beat with beat_idx=3: stores go to DONE; loads go to WAIT.
REQ-026 Load capture: in the cycle after each accepted read beat i, mem_rdata is written into load_vec[i], including the beat-3 capture in WAIT.
REQ-027 WAIT lasts exactly one cycle, then goes to DONE.
REQ-028 DONE lasts one cycle with done=1, then goes to IDLE; done=0 in all other states.
REQ-029 load_vec holds its value until overwritten by a later load; stores never modify it.
REQ-030 Latency with no stalls: start sampled at edge 0, beats in cycles 1-4; store done in cycle 5; load done in cycle 6; each stall cycle adds 1.
REQ-031 A new start is accepted in the IDLE cycle after DONE at the earliest; there is no back-to-back overlap.

Reset
REQ-032 rst_n=0 at a rising edge forces IDLE, beat_idx=0, latched operands=0, load_vec all 0, busy=0, done=0, and all mem_* outputs 0.
REQ-033 Reset mid-operation abandons the transfer; remaining beats are not issued, done does not pulse, and partially captured load data is cleared.

Verification
REQ-034 Store: base=0x100, store_vec={A,B,C,D}, no stall -> mem_we high cycles 1-4 with addr 0x100..0x103 and wdata A..D; done in cycle 5; busy cycles 1-5.
REQ-035 Load: base=0x20, memory returns 0x11,0x22,0x33,0x44 -> load_vec={0x11,0x22,0x33,0x44}; done in cycle 6; mem_we never high.
REQ-036 Stall: store with mem_stall=1 during beat 1 for 2 cycles -> addr 0x101 and wdata held 3 cycles; done in cycle 7.
REQ-037 Wrap: load at base=0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-038 Start while busy: pulse start in cycle 3 with different base -> ignored, and the original transfer completes unchanged.
REQ-039 Reset: assert rst_n=0 in cycle 3 of a load -> next cycle IDLE, all outputs 0, no done pulse; a fresh start then completes normally.
